pe_ref_scan_ctrl: RTL and testbench

Sequencer for the motion-estimation PE array. It streams current-block (CB) pixels into one of two ping-pong CB banks while the other bank is compared against the reference window. It drives the PE control lines `in_curr_enable`, `CB_select`, `change_curr`, `abs_Control`, `change_ref` and `ref_input_Control`. It flags each valid SAD candidate position to the downstream SAD tree and best-match logic.

---
 rtl/me_pkg.sv | 26 ++
 rtl/pe_cb_loader.sv | 64 ++++++
 rtl/pe_ref_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pe_ref_scan_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation PE sequencer: reference shift codes,
// search-state encoding and the serpentine shift-code helper.
package me_pkg;

  localparam int CB_SEL_W = 3;

  localparam logic [1:0] REF_UP1 = 2'b00;
  localparam logic [1:0] REF_UP8 = 2'b01;
  localparam logic [1:0] REF_DN1 = 2'b10;
  localparam logic [1:0] REF_DN8 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SCAN,
    S_DONE
  } srch_state_e;

  // Even columns walk down the window (DN1), odd columns walk back up (UP1);
  // the last row of any column hops one column over (UP8).
  function automatic logic [1:0] serp_code(input logic odd_col, input logic col_end);
    if (col_end) return REF_UP8;
    return odd_col ? REF_UP1 : REF_DN1;
  endfunction

endpackage

// File: rtl/pe_cb_loader.sv
// Current-block loader: counts pixel handshakes into the active ping-pong bank,
// marks the bank full after CB_PIX pixels and flips to the other bank.
module pe_cb_loader #(
  parameter int CB_PIX = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic       full_clr,
  input  logic       clr_bank,
  input  logic       abort,
  output logic       pix_ready,
  output logic       pix_take,
  output logic [1:0] full,
  output logic       load_bank
);

  localparam int CW = (CB_PIX > 1) ? $clog2(CB_PIX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CB_PIX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    full_q, full_d;
  logic          load_bank_q, load_bank_d;

  assign pix_ready = !full_q[load_bank_q];
  assign pix_take  = pix_valid & pix_ready;
  assign full      = full_q;
  assign load_bank = load_bank_q;

  always_comb begin
    cnt_d       = cnt_q;
    full_d      = full_q;
    load_bank_d = load_bank_q;
    if (pix_take) begin
      if (cnt_q == CNT_LAST) begin
        full_d[load_bank_q] = 1'b1;
        load_bank_d         = ~load_bank_q;
        cnt_d               = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // The search only ever releases the bank it owns, never the one being loaded.
    if (full_clr) full_d[clr_bank] = 1'b0;
    if (abort) begin
      cnt_d       = '0;
      full_d      = '0;
      load_bank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      full_q      <= '0;
      load_bank_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      load_bank_q <= load_bank_d;
    end
  end

endmodule

// File: rtl/pe_ref_scan_ctrl.sv
// PE-array sequencer: ping-pong CB loading plus reference preload and serpentine scan.
// Optional feature macro ME_ABORT_EN adds an 'abort' input that cancels a search.
module pe_ref_scan_ctrl
  import me_pkg::*;
#(
  parameter int CB_PIX = 64,
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int FILL   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cb_pix_valid,
`ifdef ME_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    cb_pix_ready,
  output logic                    in_curr_enable,
  output logic [CB_SEL_W-1:0]     CB_select,
  output logic                    change_curr,
  output logic [CB_SEL_W-1:0]     abs_Control,
  output logic                    change_ref,
  output logic [1:0]              ref_input_Control,
  output logic                    cand_valid,
  output logic [$clog2(COLS)-1:0] cand_x,
  output logic [$clog2(ROWS)-1:0] cand_y,
  output logic                    srch_busy,
  output logic                    srch_done
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int FW = (FILL > 1) ? $clog2(FILL) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILL - 1);

  srch_state_e   state_q, state_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic          cmp_bank_q, cmp_bank_d;
  logic          change_curr_q, change_curr_d;
  logic          change_ref_q, change_ref_d;
  logic [1:0]    ref_code_q, ref_code_d;
  logic          cand_valid_q, cand_valid_d;
  logic [XW-1:0] cand_x_q, cand_x_d;
  logic [YW-1:0] cand_y_q, cand_y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          abort_i;
  logic [1:0]    full;
  logic          load_bank;
  logic          pix_take;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          nxt_end, nxt_last, cur_end, cur_last;

`ifdef ME_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  pe_cb_loader #(.CB_PIX(CB_PIX)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (cb_pix_valid),
    .full_clr  (state_q == S_DONE),
    .clr_bank  (cmp_bank_q),
    .abort     (abort_i),
    .pix_ready (cb_pix_ready),
    .pix_take  (pix_take),
    .full      (full),
    .load_bank (load_bank)
  );

  // Next serpentine position; outside SCAN the next position is the origin.
  always_comb begin
    nxt_x = cand_x_q;
    nxt_y = cand_y_q;
    if (state_q != S_SCAN) begin
      nxt_x = '0;
      nxt_y = '0;
    end else if (!cand_x_q[0]) begin
      if (cand_y_q == Y_LAST) nxt_x = cand_x_q + XW'(1);
      else                    nxt_y = cand_y_q + YW'(1);
    end else begin
      if (cand_y_q == '0) nxt_x = cand_x_q + XW'(1);
      else                nxt_y = cand_y_q - YW'(1);
    end
    nxt_end  = nxt_x[0] ? (nxt_y == '0) : (nxt_y == Y_LAST);
    nxt_last = nxt_end && (nxt_x == X_LAST);
    cur_end  = cand_x_q[0] ? (cand_y_q == '0) : (cand_y_q == Y_LAST);
    cur_last = cur_end && (cand_x_q == X_LAST);
  end

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    cmp_bank_d    = cmp_bank_q;
    change_curr_d = 1'b0;
    change_ref_d  = 1'b0;
    ref_code_d    = REF_UP1;
    cand_valid_d  = 1'b0;
    cand_x_d      = '0;
    cand_y_d      = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full[cmp_bank_q]) begin
          state_d       = S_FILL;
          fill_cnt_d    = '0;
          change_curr_d = 1'b1;
          change_ref_d  = 1'b1;
          ref_code_d    = REF_DN8;
          busy_d        = 1'b1;
        end
      end
      S_FILL: begin
        busy_d = 1'b1;
        if (fill_cnt_q == F_LAST) begin
          state_d      = S_SCAN;
          cand_valid_d = 1'b1;
          cand_x_d     = nxt_x;
          cand_y_d     = nxt_y;
          change_ref_d = !nxt_last;
          ref_code_d   = nxt_last ? REF_UP1 : serp_code(nxt_x[0], nxt_end);
        end else begin
          fill_cnt_d   = fill_cnt_q + FW'(1);
          change_ref_d = 1'b1;
          ref_code_d   = REF_DN8;
        end
      end
      S_SCAN: begin
        if (cur_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d       = 1'b1;
          cand_valid_d = 1'b1;
          cand_x_d     = nxt_x;
          cand_y_d     = nxt_y;
          change_ref_d = !nxt_last;
          ref_code_d   = nxt_last ? REF_UP1 : serp_code(nxt_x[0], nxt_end);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        cmp_bank_d = ~cmp_bank_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d       = S_IDLE;
      fill_cnt_d    = '0;
      cmp_bank_d    = 1'b0;
      change_curr_d = 1'b0;
      change_ref_d  = 1'b0;
      ref_code_d    = REF_UP1;
      cand_valid_d  = 1'b0;
      cand_x_d      = '0;
      cand_y_d      = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fill_cnt_q    <= '0;
      cmp_bank_q    <= 1'b0;
      change_curr_q <= 1'b0;
      change_ref_q  <= 1'b0;
      ref_code_q    <= REF_UP1;
      cand_valid_q  <= 1'b0;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      cmp_bank_q    <= cmp_bank_d;
      change_curr_q <= change_curr_d;
      change_ref_q  <= change_ref_d;
      ref_code_q    <= ref_code_d;
      cand_valid_q  <= cand_valid_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign in_curr_enable    = pix_take;
  assign CB_select         = {{(CB_SEL_W-1){1'b0}}, load_bank};
  assign abs_Control       = {{(CB_SEL_W-1){1'b0}}, cmp_bank_q};
  assign change_curr       = change_curr_q;
  assign change_ref        = change_ref_q;
  assign ref_input_Control = ref_code_q;
  assign cand_valid        = cand_valid_q;
  assign cand_x            = cand_x_q;
  assign cand_y            = cand_y_q;
  assign srch_busy         = busy_q;
  assign srch_done         = done_q;

endmodule

// File: tb/tb_pe_ref_scan_ctrl.sv
// Directed bench for pe_ref_scan_ctrl: a 64-pixel instance for the single-block,
// reset and gappy-input cases, and a 4-pixel instance for overlap and backpressure.
module tb_pe_ref_scan_ctrl;
  import me_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int FILL = 2;

  typedef struct packed {
    logic       cc;
    logic       chg;
    logic [1:0] code;
    logic       cv;
    logic [1:0] x;
    logic [1:0] y;
    logic       done;
    logic       busy;
  } obs_t;

  typedef struct packed {
    logic valid;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic valid_m, ready_m, en_m, cc_m, chg_m, cv_m, busy_m, done_m;
  logic [2:0] sel_m, abs_m;
  logic [1:0] code_m, x_m, y_m;
  logic valid_s, ready_s, en_s, cc_s, chg_s, cv_s, busy_s, done_s;
  logic [2:0] sel_s, abs_s;
  logic [1:0] code_s, x_s, y_s;
  logic abort_m, abort_s;

  int n_pass  = 0;
  int n_total = 0;

  pe_ref_scan_ctrl #(.CB_PIX(64), .ROWS(ROWS), .COLS(COLS), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .cb_pix_valid(valid_m),
`ifdef ME_ABORT_EN
    .abort(abort_m),
`endif
    .cb_pix_ready(ready_m), .in_curr_enable(en_m), .CB_select(sel_m),
    .change_curr(cc_m), .abs_Control(abs_m), .change_ref(chg_m),
    .ref_input_Control(code_m), .cand_valid(cv_m), .cand_x(x_m), .cand_y(y_m),
    .srch_busy(busy_m), .srch_done(done_m)
  );

  pe_ref_scan_ctrl #(.CB_PIX(4), .ROWS(ROWS), .COLS(COLS), .FILL(FILL)) dut_s (
    .clk(clk), .rst_n(rst_n), .cb_pix_valid(valid_s),
`ifdef ME_ABORT_EN
    .abort(abort_s),
`endif
    .cb_pix_ready(ready_s), .in_curr_enable(en_s), .CB_select(sel_s),
    .change_curr(cc_s), .abs_Control(abs_s), .change_ref(chg_s),
    .ref_input_Control(code_s), .cand_valid(cv_s), .cand_x(x_s), .cand_y(y_s),
    .srch_busy(busy_s), .srch_done(done_s)
  );

  function automatic vec_t mk(input logic v, input logic cc, input logic chg,
                              input logic [1:0] code, input logic cv, input logic [1:0] x,
                              input logic [1:0] y, input logic done, input logic busy);
    vec_t r;
    r.valid    = v;
    r.exp.cc   = cc;
    r.exp.chg  = chg;
    r.exp.code = code;
    r.exp.cv   = cv;
    r.exp.x    = x;
    r.exp.y    = y;
    r.exp.done = done;
    r.exp.busy = busy;
    return r;
  endfunction

  function automatic obs_t snap_m();
    obs_t o;
    o.cc = cc_m; o.chg = chg_m; o.code = code_m; o.cv = cv_m;
    o.x = x_m; o.y = y_m; o.done = done_m; o.busy = busy_m;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    valid_m = v.valid;
    #1;
  endtask

  task automatic stream_block(input int n, output int hs);
    hs = 0;
    for (int i = 0; i < n; i++) begin
      valid_m = 1'b1;
      #1;
      if (en_m) hs++;
      step();
    end
    valid_m = 1'b0;
  endtask

  vec_t tbl [19];
  int   hs;
  int   blocked;
  logic done_seen;

  initial begin
    tbl[0]  = mk(0, 1, 1, 2'b11, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 1, 2'b11, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 1, 2'b10, 1, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 2'b10, 1, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0, 1, 2'b10, 1, 0, 2, 0, 1);
    tbl[5]  = mk(0, 0, 1, 2'b01, 1, 0, 3, 0, 1);
    tbl[6]  = mk(0, 0, 1, 2'b00, 1, 1, 3, 0, 1);
    tbl[7]  = mk(0, 0, 1, 2'b00, 1, 1, 2, 0, 1);
    tbl[8]  = mk(0, 0, 1, 2'b00, 1, 1, 1, 0, 1);
    tbl[9]  = mk(0, 0, 1, 2'b01, 1, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 2'b10, 1, 2, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 2'b10, 1, 2, 1, 0, 1);
    tbl[12] = mk(0, 0, 1, 2'b10, 1, 2, 2, 0, 1);
    tbl[13] = mk(0, 0, 1, 2'b01, 1, 2, 3, 0, 1);
    tbl[14] = mk(0, 0, 1, 2'b00, 1, 3, 3, 0, 1);
    tbl[15] = mk(0, 0, 1, 2'b00, 1, 3, 2, 0, 1);
    tbl[16] = mk(0, 0, 1, 2'b00, 1, 3, 1, 0, 1);
    tbl[17] = mk(0, 0, 0, 2'b00, 1, 3, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);

    valid_m = 1'b0; valid_s = 1'b0; abort_m = 1'b0; abort_s = 1'b0;

    // Reset values, during and right after reset
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_obs", 32'(snap_m()), 32'd0);
    check_output("reset_ready", 32'(ready_m), 32'd1);
    rst_n = 1'b1;
    step();
    check_output("post_reset_sel_abs", {26'd0, sel_m, abs_m}, 32'd0);
    check_output("post_reset_obs", 32'(snap_m()), 32'd0);

    // Single block, then table-driven walk through FILL, SCAN and DONE
    stream_block(64, hs);
    check_output("single_hs_count", 32'(hs), 32'd64);
    check_output("t1_chg_ready_sel", {28'd0, chg_m, ready_m, sel_m[1:0]}, {28'd0, 4'b0101});
    for (int i = 0; i < 19; i++) begin
      step();
      apply_stimulus(tbl[i]);
      check_output($sformatf("scan_vec%0d", i), 32'(snap_m()), 32'(tbl[i].exp));
    end
    step();
    check_output("idle_after_done_abs", 32'(abs_m), 32'd1);
    check_output("idle_after_done_obs", 32'(snap_m()), 32'd0);

    // Reset mid-load discards the partial block
    valid_m = 1'b1;
    repeat (30) step();
    rst_n = 1'b0;
    valid_m = 1'b0;
    #1;
    check_output("midreset_ready_sel", {28'd0, ready_m, sel_m}, {28'd0, 4'b1000});
    step();
    rst_n = 1'b1;
    step();

    // Gappy input: one pixel every other cycle
    hs = 0;
    for (int c = 0; c <= 130; c++) begin
      valid_m = (c < 128) && (c % 2 == 0);
      #1;
      if (en_m) hs++;
      if (c == 126) check_output("gappy_hs_at126", 32'(hs), 32'd64);
      if (c == 127) check_output("gappy_no_start_127", {30'd0, cc_m, busy_m}, 32'd0);
      if (c == 128) check_output("gappy_start_128", {28'd0, cc_m, chg_m, code_m}, 32'b1111);
      if (c == 130) check_output("gappy_first_cand", {27'd0, cv_m, x_m, y_m}, 32'b10000);
      step();
    end
    valid_m = 1'b0;

    // Overlap and backpressure on the 4-pixel instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    blocked = 0;
    valid_s = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      #1;
      if (c >= 8 && c <= 23 && en_s) blocked++;
      if (c == 5)  check_output("ovl_first_fill", {28'd0, cc_s, abs_s}, 32'b1000);
      if (c == 7)  check_output("ovl_load2_sel", {28'd0, ready_s, sel_s}, 32'b1001);
      if (c == 8)  check_output("bp_ready_low", {28'd0, ready_s, sel_s}, 32'b0000);
      if (c == 23) check_output("bp_at_done", {27'd0, ready_s, done_s, abs_s}, 32'b01000);
      if (c == 23) check_output("bp_no_handshakes", 32'(blocked), 32'd0);
      if (c == 24) check_output("bp_ready_after_done", {26'd0, ready_s, chg_s, busy_s, abs_s}, 32'b100001);
      if (c == 25) check_output("b2b_second_fill", {27'd0, cc_s, busy_s, abs_s}, 32'b11001);
      step();
    end
    valid_s = 1'b0;

`ifdef ME_ABORT_EN
    // Abort on the fifth SCAN cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    stream_block(64, hs);
    repeat (7) step();
    check_output("abort_5th_cand", {27'd0, cv_m, x_m, y_m}, 32'b10111);
    abort_m = 1'b1;
    step();
    abort_m = 1'b0;
    check_output("abort_next_obs", 32'(snap_m()), 32'd0);
    check_output("abort_ready_sel_abs", {25'd0, ready_m, sel_m, abs_m}, 32'b1000000);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_m || cv_m) done_seen = 1'b1;
      step();
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
